regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port between N write-back requesters (ALU, load unit, ...).
//  Round-robin arbitration, valid/ready per requester, registered write command to the register file.
//  Optional power-up sequencer clears all 2^D registers before the first grant.
//  Sits between the write-back stage sources and register_file address3/write_data/write_enable.
// PARAMETERS
//  N  3   number of requesters (N>=2)
//  D  5   register address width (2^D registers); must match register_file D
//  W  32  data width; must match register_file W
// PORTS
//  clk               in   1      clock; all state updates on posedge
//  rst_n             in   1      synchronous reset, active-low
//  req_valid         in   N      requester i has a write pending
//  req_addr          in   N*D    destination register of requester i (packed, i*D LSB-first)
//  req_data          in   N*W    write data of requester i (packed, i*W LSB-first)
//  req_ready         out  N      one-hot-or-zero grant; transfer when valid&ready
//  rf_address        out  D      to register_file address3
//  rf_write_data     out  W      to register_file write_data
//  rf_write_enable   out  1      to register_file write_enable
//  init_done         out  1      high once clear sequence finished (always high when feature off)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rf_write_enable=0, rf_address=0, rf_write_data=0, rr pointer=0,
//   state=INIT (macro on) / RUN (macro off), init_done=0 (on) / 1 (off). req_ready=0 while rst_n=0.
//  FSM: INIT -> RUN when clear counter reaches 2^D-1; RUN holds until reset. No other states.
//  INIT: each cycle drives rf_write_enable=1, rf_address=counter, rf_write_data=0; counter +1;
//   req_ready=0 throughout; takes exactly 2^D cycles; init_done rises the cycle RUN is entered.
//  RUN arbitration (combinational): search from pointer p upward modulo N; first i with req_valid[i]
//   gets req_ready[i]=1; all others 0. No valid -> req_ready=0, pointer unchanged.
//  req_ready may depend combinationally on req_valid; requesters must not make valid depend on ready.
//  On transfer by i at cycle t: pointer <= (i+1) mod N; at t+1 rf_write_enable=1, rf_address/rf_write_data
//   = captured req_addr[i]/req_data[i]; register file updates at end of t+1 (latency 1 to write strobe).
//  No transfer at t -> rf_write_enable=0 at t+1; rf_address/rf_write_data hold previous values.
//  Throughput: one write per cycle, back-to-back grants allowed, no bubbles.
//  Fairness: with all N valid continuously, each requester granted exactly once every N cycles.
//  Simultaneous same-address requests: serialized in grant order; later grant wins in register file.
//  Address 0 not special; writes to any register accepted.
//  Reset mid-operation: in-flight captured write dropped (write_enable=0 next cycle), sequence restarts.
//  Pointer wrap: (N-1)+1 -> 0.
// CONFIGURATION
//  REGFILE_WRITE_ARB_INIT_CLEAR_EN defined: INIT state and clear counter present as above.
//  Undefined: no INIT state, no counter; after reset FSM is RUN, init_done tied 1, grants from
//   first cycle after reset release; register contents undefined until written.
// STRUCTURE
//  Shared package regfile_pkg: DEFAULT_D=5, DEFAULT_W=32, typedef enum logic {ARB_INIT, ARB_RUN}
//   arb_state_t, typedef for rf write command struct {addr, data, we}.
//  One sub-module: rr_arbiter #(N) (req vector, pointer -> one-hot grant, grant index); pointer
//   register lives in regfile_write_arbiter.
// TESTING
//  Macro on, reset release: 32 cycles write_enable=1, address 0..31, data 0; ready=0; init_done at cycle 32.
//  N=3 all valid 6 cycles, addr 1/2/3 data A/B/C: grants 0,1,2,0,1,2; writes appear 1 cycle later.
//  Only req 2 valid, pointer 0: grant 2 same cycle; pointer becomes 0 (wrap); next cycle req 0+1 valid -> 0.
//  Req 0 and 1 both write addr 7 (data 0x11, 0x22): rf sees 0x11 then 0x22; readback reg7=0x22.
//  rst_n low during a granted cycle: next cycle write_enable=0, pointer=0, clear sequence restarts.
//  Macro off: first cycle after reset, req 1 valid -> ready[1]=1; init_done=1 continuously.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package regfile_pkg;

  localparam int DEFAULT_D = 5;
  localparam int DEFAULT_W = 32;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_t;

  // Write command as presented to the register file write port.
  typedef struct packed {
    logic [DEFAULT_D-1:0] addr;
    logic [DEFAULT_W-1:0] data;
    logic                 we;
  } rf_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: the first requester at or above ptr
// (modulo N) wins. Purely combinational; the pointer lives in the parent.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]                      req,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                      grant,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] idx,
  output logic                              any
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Walk N slots starting at ptr, wrapping once; keep the first hit.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port among N write-back
// sources, with a registered write command (one cycle to the write strobe).
// Optional feature macro REGFILE_WRITE_ARB_INIT_CLEAR_EN: after reset, an
// INIT phase zeroes every register before any requester is granted.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N = 3,
  parameter int D = DEFAULT_D,
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*D-1:0] req_addr,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [D-1:0]   rf_address,
  output logic [W-1:0]   rf_write_data,
  output logic           rf_write_enable,
  output logic           init_done
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic         we;
  } wr_cmd_t;

  arb_state_t    state, state_nxt;
  logic [PW-1:0] ptr, gidx;
  logic [N-1:0]  grant;
  logic          gany;
  logic          run;
  logic          xfer;
  wr_cmd_t       cmd;

  rr_arbiter #(.N(N)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign run       = (state == ARB_RUN);
  // Grants are suppressed during reset and during the clear phase.
  assign req_ready = (rst_n && run) ? grant : '0;
  assign xfer      = rst_n && run && gany;

`ifdef REGFILE_WRITE_ARB_INIT_CLEAR_EN
  logic [D-1:0] clr_cnt;

  // Clear counter walks every register address once during INIT.
  always_ff @(posedge clk) begin
    if (!rst_n)                  clr_cnt <= '0;
    else if (state == ARB_INIT)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Next state: leave INIT after the last address has been cleared.
  always_comb begin
    state_nxt = state;
    if (state == ARB_INIT && clr_cnt == '1) state_nxt = ARB_RUN;
  end

  // State register; the clear sequence restarts on every reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_INIT;
    else        state <= state_nxt;
  end

  // INIT drives the clear write straight from the counter; RUN uses the
  // registered command. Reset masks the clear write immediately.
  always_comb begin
    rf_address      = cmd.addr;
    rf_write_data   = cmd.data;
    rf_write_enable = cmd.we;
    if (state == ARB_INIT && rst_n) begin
      rf_address      = clr_cnt;
      rf_write_data   = '0;
      rf_write_enable = 1'b1;
    end
  end

  assign init_done = run;
`else
  // Without the clear phase the FSM has only RUN.
  always_comb begin
    state_nxt = state;
  end

  // State register: always RUN out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_RUN;
    else        state <= state_nxt;
  end

  assign rf_address      = cmd.addr;
  assign rf_write_data   = cmd.data;
  assign rf_write_enable = cmd.we;
  assign init_done       = 1'b1;
`endif

  // Pointer moves just past the winner, so it has lowest priority next.
  always_ff @(posedge clk) begin
    if (!rst_n)    ptr <= '0;
    else if (xfer) ptr <= (gidx == PW'(N-1)) ? '0 : gidx + PW'(1);
  end

  // Capture the winner's command; without a transfer only the strobe drops
  // and address/data hold. Reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (xfer) begin
      cmd.addr <= req_addr[int'(gidx)*D +: D];
      cmd.data <= req_data[int'(gidx)*W +: W];
      cmd.we   <= 1'b1;
    end else begin
      cmd.we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed and random stimulus against a
// cycle-level reference model of the grant order and write command.
module tb_regfile_write_arbiter;
  localparam int N = 3;
  localparam int D = 5;
  localparam int W = 32;
`ifdef REGFILE_WRITE_ARB_INIT_CLEAR_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*D-1:0] req_addr;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [D-1:0]   rf_address;
  logic [W-1:0]   rf_write_data;
  logic           rf_write_enable;
  logic           init_done;

  regfile_write_arbiter #(.N(N), .D(D), .W(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rf_address      (rf_address),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .init_done       (init_done)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port, for readback checks.
  logic [W-1:0] tb_rf [2**D];
  always @(posedge clk) if (rf_write_enable === 1'b1) tb_rf[rf_address] <= rf_write_data;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int           p        = 0;
  logic         exp_we   = 1'b0;
  logic [D-1:0] exp_addr = '0;
  logic [W-1:0] exp_data = '0;
  bit           in_init  = INIT_ON;
  int           init_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic cyc(input logic [N-1:0] v, input logic [N*D-1:0] a,
                     input logic [N*W-1:0] d, input logic r);
    int g;
    logic [N-1:0] er;
    req_valid = v; req_addr = a; req_data = d; rst_n = r;
    g = -1;
    if (r && !in_init)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(p + k) % N]) g = (p + k) % N;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    @(negedge clk);
    chk("ready", 64'(req_ready), 64'(er));
    if (in_init && r) begin
      chk("clr_we",   64'(rf_write_enable), 64'(1));
      chk("clr_addr", 64'(rf_address),      64'(init_cnt));
      chk("clr_data", 64'(rf_write_data),   64'(0));
    end else begin
      chk("we",   64'(rf_write_enable), 64'(exp_we));
      chk("addr", 64'(rf_address),      64'(exp_addr));
      chk("data", 64'(rf_write_data),   64'(exp_data));
    end
    chk("init_done", 64'(init_done), 64'(!in_init));
    @(posedge clk); #1;
    if (!r) begin
      p = 0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      in_init = INIT_ON; init_cnt = 0;
    end else if (in_init) begin
      init_cnt++;
      if (init_cnt == (1 << D)) in_init = 1'b0;
    end else if (g >= 0) begin
      exp_we = 1'b1; exp_addr = a[g*D +: D]; exp_data = d[g*W +: W];
      p = (g + 1) % N;
    end else begin
      exp_we = 1'b0;
    end
  endtask

  task automatic rnd_cyc(input logic r);
    logic [N*W-1:0] d;
    d = {$urandom, $urandom, $urandom};
    cyc(N'($urandom_range(0, (1 << N) - 1)), (N*D)'($urandom), d, r);
  endtask

  // Run through the clear phase (no-op when the feature is off).
  task automatic settle();
    int guard = 0;
    while (in_init && guard < 100) begin
      rnd_cyc(1'b1);
      guard++;
    end
  endtask

  initial begin
    logic [N*D-1:0] a;
    logic [N*W-1:0] d;
    a = '0; d = '0;

    // Reset, then requester 1 alone on the first released cycle.
    cyc('0, a, d, 1'b0);
    cyc('0, a, d, 1'b0);
    cyc(3'b010, a, d, 1'b1);
    settle();

    // Fresh reset; all valid for 6 cycles: grants 0,1,2,0,1,2.
    cyc('0, a, d, 1'b0);
    settle();
    a = {5'd3, 5'd2, 5'd1};
    d = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    for (int i = 0; i < 6; i++) cyc(3'b111, a, d, 1'b1);
    cyc('0, a, d, 1'b1);
    cyc('0, a, d, 1'b1);

    // Pointer is 0: only req 2 -> granted, pointer wraps to 0; then 0+1 -> 0.
    cyc(3'b100, a, d, 1'b1);
    cyc(3'b011, a, d, 1'b1);
    cyc('0, a, d, 1'b1);

    // Same address from req 0 then req 1; later grant must win.
    cyc(3'b100, a, d, 1'b1);
    a = {5'd0, 5'd7, 5'd7};
    d = {32'h0, 32'h22, 32'h11};
    cyc(3'b011, a, d, 1'b1);
    cyc(3'b010, a, d, 1'b1);
    cyc('0, a, d, 1'b1);
    cyc('0, a, d, 1'b1);
    chk("reg7", 64'(tb_rf[7]), 64'(32'h22));

    // Reset arriving right after a granted cycle drops the write.
    a = {5'd9, 5'd8, 5'd6};
    cyc(3'b111, a, d, 1'b1);
    cyc(3'b111, a, d, 1'b0);
    cyc(3'b111, a, d, 1'b1);
    settle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) rnd_cyc($urandom_range(0, 39) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
